ram_16k_arbiter: RTL and testbench

- Shares one single-port ram_16K (16K x 16) between two requesters, e.g. the CPU data port and a screen/DMA engine.
- Accepts at most one access per clock using a combinational req/gnt handshake.
- Drives the RAM address, data and load pins, and returns registered read data to the winning requester.
- Arbitration is round-robin with a burst cap; a fixed-priority build is selectable by macro.

---
 rtl/ram_16k_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_16k_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_16k_arbiter.sv
// Two-port arbiter in front of a single-port 16K x 16 RAM, one access per clock.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin with a burst cap; otherwise port 0 has fixed priority.
module ram_16k_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [13:0] addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [13:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic [13:0] ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  if (MAX_BURST == 0 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..15");
  end

  logic        w_gnt0;
  logic        w_gnt1;
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic       r_owner;
  logic [3:0] r_burst_cnt;
  logic       w_owner_d;
  logic [3:0] w_burst_cnt_d;
  logic       w_owner_keeps;

  always_comb begin
    w_gnt0        = 1'b0;
    w_gnt1        = 1'b0;
    w_owner_keeps = (r_burst_cnt < MaxBurst);
    if (reset_n) begin
      if (req0 && req1) begin
        // On a tie the owner keeps the RAM until its burst budget is spent.
        w_gnt1 = w_owner_keeps ? r_owner : !r_owner;
        w_gnt0 = !w_gnt1;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  always_comb begin
    w_owner_d     = r_owner;
    w_burst_cnt_d = r_burst_cnt;
    if (w_gnt0 || w_gnt1) begin
      if (w_gnt1 == r_owner) begin
        if (r_burst_cnt < MaxBurst) begin
          w_burst_cnt_d = r_burst_cnt + 4'd1;
        end
      end else begin
        w_owner_d     = w_gnt1;
        w_burst_cnt_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= 1'b1;
      r_burst_cnt <= MaxBurst;
    end else begin
      r_owner     <= w_owner_d;
      r_burst_cnt <= w_burst_cnt_d;
    end
  end
`else
  always_comb begin
    w_gnt0 = reset_n & req0;
    w_gnt1 = reset_n & req1 & ~req0;
  end
`endif

  // Idle cycles park the RAM on port 0 inputs with load held low.
  always_comb begin
    ram_address = addr0;
    ram_in      = wdata0;
    ram_load    = w_gnt0 & we0;
    if (w_gnt1) begin
      ram_address = addr1;
      ram_in      = wdata1;
      ram_load    = we1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 16'h0000;
      r_rdata1  <= 16'h0000;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (w_gnt0 && !we0) begin
        r_rdata0 <= ram_out;
      end
      if (w_gnt1 && !we1) begin
        r_rdata1 <= ram_out;
      end
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_ram_16k_arbiter.sv
// Directed bench for ram_16k_arbiter with a behavioural 16K x 16 RAM attached.
// Expectations follow RAM_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_ram_16k_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0, we0, gnt0, rvalid0;
  logic [13:0] addr0;
  logic [15:0] wdata0, rdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [13:0] addr1;
  logic [15:0] wdata1, rdata1;
  logic [13:0] ram_address;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;

  logic [15:0] mem [0:16383];

  int n_cmp = 0;
  int n_err = 0;

  ram_16k_arbiter #(
    .MAX_BURST (4)
  ) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .gnt0        (gnt0),
    .rvalid0     (rvalid0),
    .rdata0      (rdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt1        (gnt1),
    .rvalid1     (rvalid1),
    .rdata1      (rdata1),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wr0(input logic [13:0] a, input logic [15:0] d);
    req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
    step();
    req0 = 1'b0; we0 = 1'b0;
  endtask

  // Tie pattern from reset with MAX_BURST = 4: 0000 1111 0000 ...
  function automatic int exp_win(input int i);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    return (i / 4) % 2;
`else
    return 0;
`endif
  endfunction

  initial begin
    int prev;
    int w;
    reset_n = 1'b0;
    idle_inputs();
    req0 = 1'b1;
    we0  = 1'b1;
    #1;
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_load", ram_load, 1'b0);
    check_eq("rst_rvalid0", rvalid0, 1'b0);
    check_eq("rst_rvalid1", rvalid1, 1'b0);
    check_eq("rst_rdata0", rdata0, 16'h0000);
    check_eq("rst_rdata1", rdata1, 16'h0000);
    do_reset();

    // Single write then read-back on port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0123; wdata0 = 16'hBEEF;
    #1;
    check_eq("wr_gnt0", gnt0, 1'b1);
    check_eq("wr_gnt1", gnt1, 1'b0);
    check_eq("wr_load", ram_load, 1'b1);
    check_eq("wr_addr", 16'(ram_address), 16'h0123);
    check_eq("wr_in", ram_in, 16'hBEEF);
    step();
    we0 = 1'b0;
    #1;
    check_eq("rd_gnt0", gnt0, 1'b1);
    check_eq("rd_load", ram_load, 1'b0);
    check_eq("wr_no_rvalid", rvalid0, 1'b0);
    step();
    req0 = 1'b0;
    #1;
    check_eq("rd_rvalid0", rvalid0, 1'b1);
    check_eq("rd_rdata0", rdata0, 16'hBEEF);
    check_eq("idle_gnt0", gnt0, 1'b0);
    step();
    check_eq("rvalid0_pulse", rvalid0, 1'b0);
    check_eq("rdata0_hold", rdata0, 16'hBEEF);

    wr0(14'h0010, 16'hA0A0);
    wr0(14'h0020, 16'hB1B1);
    do_reset();

    // Both ports hold read requests for 20 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0020;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      w = exp_win(i);
      check_eq($sformatf("tie_gnt0_%0d", i), gnt0, (w == 0));
      check_eq($sformatf("tie_gnt1_%0d", i), gnt1, (w == 1));
      check_eq($sformatf("tie_addr_%0d", i), 16'(ram_address), (w == 1) ? 16'h0020 : 16'h0010);
      check_eq($sformatf("tie_rvalid0_%0d", i), rvalid0, (prev == 0));
      check_eq($sformatf("tie_rvalid1_%0d", i), rvalid1, (prev == 1));
      if (prev == 0) check_eq($sformatf("tie_rdata0_%0d", i), rdata0, 16'hA0A0);
      if (prev == 1) check_eq($sformatf("tie_rdata1_%0d", i), rdata1, 16'hB1B1);
      prev = w;
      step();
    end
    idle_inputs();
    #1;
    check_eq("tie_last_rvalid0", rvalid0, (prev == 0));

    // Cross-port coherence at the top address
    step();
    req1 = 1'b1; we1 = 1'b1; addr1 = 14'h3FFF; wdata1 = 16'h1234;
    addr0 = 14'h3FFF; we0 = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    req0 = 1'b1;
`else
    req0 = 1'b0;
`endif
    #1;
    check_eq("coh_gnt1", gnt1, 1'b1);
    check_eq("coh_gnt0", gnt0, 1'b0);
    check_eq("coh_load", ram_load, 1'b1);
    check_eq("coh_addr", 16'(ram_address), 16'h3FFF);
    check_eq("coh_in", ram_in, 16'h1234);
    step();
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1;
    #1;
    check_eq("coh_rd_gnt0", gnt0, 1'b1);
    check_eq("coh_wr_no_rvalid1", rvalid1, 1'b0);
    step();
    req0 = 1'b0;
    #1;
    check_eq("coh_rvalid0", rvalid0, 1'b1);
    check_eq("coh_rdata0", rdata0, 16'h1234);

    // Lone requester beyond the burst cap, then a tie goes to port 0
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0020;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("sat_gnt1_%0d", i), gnt1, 1'b1);
      step();
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0010;
    #1;
    check_eq("sat_tie_gnt0", gnt0, 1'b1);
    check_eq("sat_tie_gnt1", gnt1, 1'b0);
    check_eq("sat_rvalid1", rvalid1, 1'b1);
    check_eq("sat_rdata1", rdata1, 16'hB1B1);
    step();
    idle_inputs();

    // Reset asserted while port 1 read is granted
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0020;
    #1;
    check_eq("mr_gnt1_a", gnt1, 1'b1);
    step();
    check_eq("mr_gnt1_b", gnt1, 1'b1);
    check_eq("mr_rvalid1_pre", rvalid1, 1'b1);
    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0010; wdata0 = 16'hDEAD;
    #1;
    check_eq("mr_gnt0", gnt0, 1'b0);
    check_eq("mr_gnt1", gnt1, 1'b0);
    check_eq("mr_load", ram_load, 1'b0);
    check_eq("mr_rvalid1", rvalid1, 1'b0);
    check_eq("mr_rdata1", rdata1, 16'h0000);
    check_eq("mr_rdata0", rdata0, 16'h0000);
    step();
    check_eq("mr_rvalid1_edge", rvalid1, 1'b0);
    check_eq("mr_load_edge", ram_load, 1'b0);
    check_eq("mr_mem_kept", mem[14'h0010], 16'hA0A0);
    idle_inputs();
    #1;
    reset_n = 1'b1;

    // Ten-cycle tie, then port 0 drops
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0020;
    for (int i = 0; i < 10; i++) begin
      #1;
      w = exp_win(i);
      check_eq($sformatf("fp_gnt0_%0d", i), gnt0, (w == 0));
      check_eq($sformatf("fp_gnt1_%0d", i), gnt1, (w == 1));
      step();
    end
    req0 = 1'b0;
    #1;
    check_eq("fp_drop_gnt1", gnt1, 1'b1);
    check_eq("fp_drop_gnt0", gnt0, 1'b0);
    step();
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
